// File: rtl/rcc_bdcr_wren_gen.sv
// BDCR write-strobe generator: SETUP -> PULSE -> HOLD sequencing of per-byte write strobes.
// Optional define RCC_BDCR_WREN_SHADOW_EN adds a shadow copy of the bytes written (shadow_bdcr).
module rcc_bdcr_wren_gen #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic        rcc_hclk,
  input  logic        rcc_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_wdata,
  input  logic [2:0]  req_byte_en,
  input  logic        dbp,
  output logic [23:0] bdcr_wdata,
  output logic        raw_rcc_bdcr_byte2_wren,
  output logic        raw_rcc_bdcr_byte1_wren,
  output logic        raw_rcc_bdcr_byte0_wren,
  output logic        done,
  output logic        prot_err
`ifdef RCC_BDCR_WREN_SHADOW_EN
  ,
  output logic [23:0] shadow_bdcr
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYC - 1);
  localparam logic [2:0] PULSE_LAST = 3'(PULSE_CYC - 1);
  localparam logic [2:0] HOLD_LAST  = 3'(HOLD_CYC - 1);

  logic [1:0] state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [2:0] mask;
  logic [2:0] wren_q;
  logic       accept;
  logic       start;
  logic       last_hold_nxt;

  assign req_ready     = (state == IDLE) && !rcc_rst;
  assign accept        = req_valid && req_ready;
  assign start         = accept && dbp && (req_byte_en != 3'b000);
  assign last_hold_nxt = (state_nxt == HOLD) && (cnt_nxt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Strobes, done and prot_err are registered from next-state so every output is a bare flop.
  always_ff @(posedge rcc_hclk or posedge rcc_rst) begin
    if (rcc_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mask       <= '0;
      bdcr_wdata <= '0;
      wren_q     <= '0;
      done       <= 1'b0;
      prot_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wren_q   <= (state_nxt == PULSE) ? mask : '0;
      done     <= last_hold_nxt || (accept && dbp && (req_byte_en == 3'b000));
      prot_err <= accept && !dbp;
      if (start) begin
        mask       <= req_byte_en;
        bdcr_wdata <= req_wdata;
      end
    end
  end

  assign raw_rcc_bdcr_byte2_wren = wren_q[2];
  assign raw_rcc_bdcr_byte1_wren = wren_q[1];
  assign raw_rcc_bdcr_byte0_wren = wren_q[0];

`ifdef RCC_BDCR_WREN_SHADOW_EN
  always_ff @(posedge rcc_hclk or posedge rcc_rst) begin
    if (rcc_rst) begin
      shadow_bdcr <= '0;
    end else if (last_hold_nxt) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (mask[i]) shadow_bdcr[8*i +: 8] <= bdcr_wdata[8*i +: 8];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rcc_bdcr_wren_gen.sv
// Directed self-checking bench for rcc_bdcr_wren_gen (default parameters).
module tb_rcc_bdcr_wren_gen;

  logic        rcc_hclk = 1'b0;
  logic        rcc_rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_wdata;
  logic [2:0]  req_byte_en;
  logic        dbp;
  logic [23:0] bdcr_wdata;
  logic        wren2, wren1, wren0;
  logic        done;
  logic        prot_err;
`ifdef RCC_BDCR_WREN_SHADOW_EN
  logic [23:0] shadow_bdcr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 rcc_hclk = ~rcc_hclk;

  rcc_bdcr_wren_gen #(.SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(2)) dut (
    .rcc_hclk                (rcc_hclk),
    .rcc_rst                 (rcc_rst),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_wdata               (req_wdata),
    .req_byte_en             (req_byte_en),
    .dbp                     (dbp),
    .bdcr_wdata              (bdcr_wdata),
    .raw_rcc_bdcr_byte2_wren (wren2),
    .raw_rcc_bdcr_byte1_wren (wren1),
    .raw_rcc_bdcr_byte0_wren (wren0),
    .done                    (done),
    .prot_err                (prot_err)
`ifdef RCC_BDCR_WREN_SHADOW_EN
    ,
    .shadow_bdcr             (shadow_bdcr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts cycle 0 of a request: inputs applied just after a rising edge.
  task automatic issue(input logic [23:0] d, input logic [2:0] be, input logic p);
    @(posedge rcc_hclk); #1;
    req_valid   = 1'b1;
    req_wdata   = d;
    req_byte_en = be;
    dbp         = p;
    @(negedge rcc_hclk);
    check("ready_c0", {31'd0, req_ready}, 32'd1);
  endtask

  logic [2:0] strb;
  int         w0_cnt;

  initial begin
    rcc_rst     = 1'b1;
    req_valid   = 1'b0;
    req_wdata   = '0;
    req_byte_en = '0;
    dbp         = 1'b0;

    // Reset state
    repeat (3) @(posedge rcc_hclk);
    @(negedge rcc_hclk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_wdata", {8'd0, bdcr_wdata}, 32'd0);
    check("rst_strb",  {29'd0, wren2, wren1, wren0}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_perr",  {31'd0, prot_err}, 32'd0);
    @(posedge rcc_hclk); #1;
    rcc_rst = 1'b0;
    @(negedge rcc_hclk);
    check("rel_ready", {31'd0, req_ready}, 32'd1);

    // Basic write: 0xA5C33C, bytes 2 and 0
    issue(24'hA5C33C, 3'b101, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge rcc_hclk); #1;
      if (k == 1) begin
        req_valid = 1'b0;
        req_wdata = 24'h000000;
        dbp       = 1'b0;
      end
      @(negedge rcc_hclk);
      strb = (k == 3 || k == 4) ? 3'b101 : 3'b000;
      check($sformatf("w1_wdata_c%0d", k), {8'd0, bdcr_wdata}, 32'hA5C33C);
      check($sformatf("w1_strb_c%0d", k), {29'd0, wren2, wren1, wren0}, {29'd0, strb});
      check($sformatf("w1_done_c%0d", k), {31'd0, done}, (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("w1_ready_c%0d", k), {31'd0, req_ready}, (k >= 7) ? 32'd1 : 32'd0);
    end

    // Protected write rejected
    issue(24'hFFFFFF, 3'b111, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge rcc_hclk); #1;
      if (k == 1) req_valid = 1'b0;
      @(negedge rcc_hclk);
      check($sformatf("pe_perr_c%0d", k), {31'd0, prot_err}, (k == 1) ? 32'd1 : 32'd0);
      check($sformatf("pe_strb_c%0d", k), {29'd0, wren2, wren1, wren0}, 32'd0);
      check($sformatf("pe_wdata_c%0d", k), {8'd0, bdcr_wdata}, 32'hA5C33C);
      check($sformatf("pe_done_c%0d", k), {31'd0, done}, 32'd0);
    end

    // Empty byte mask: immediate done, no strobe
    issue(24'h123456, 3'b000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge rcc_hclk); #1;
      if (k == 1) req_valid = 1'b0;
      @(negedge rcc_hclk);
      check($sformatf("be0_done_c%0d", k), {31'd0, done}, (k == 1) ? 32'd1 : 32'd0);
      check($sformatf("be0_strb_c%0d", k), {29'd0, wren2, wren1, wren0}, 32'd0);
      check($sformatf("be0_ready_c%0d", k), {31'd0, req_ready}, 32'd1);
      check($sformatf("be0_perr_c%0d", k), {31'd0, prot_err}, 32'd0);
    end

    // Reset in cycle 3 (mid-PULSE)
    issue(24'hA5C33C, 3'b101, 1'b1);
    @(posedge rcc_hclk); #1;
    req_valid = 1'b0;
    @(posedge rcc_hclk);
    @(posedge rcc_hclk); #2;
    check("rp_strb_before", {29'd0, wren2, wren1, wren0}, 32'd5);
    rcc_rst = 1'b1;
    #1;
    check("rp_strb_async", {29'd0, wren2, wren1, wren0}, 32'd0);
    check("rp_ready_in_rst", {31'd0, req_ready}, 32'd0);
    check("rp_wdata_in_rst", {8'd0, bdcr_wdata}, 32'd0);
    @(posedge rcc_hclk); #1;
    rcc_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge rcc_hclk);
      check($sformatf("rp_done_%0d", k), {31'd0, done}, 32'd0);
      check($sformatf("rp_strb_%0d", k), {29'd0, wren2, wren1, wren0}, 32'd0);
      check($sformatf("rp_ready_%0d", k), {31'd0, req_ready}, 32'd1);
    end

    // Back-to-back with req_valid held high
    issue(24'h111111, 3'b111, 1'b1);
    w0_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge rcc_hclk); #1;
      if (k == 1) begin
        req_wdata   = 24'h222222;
        req_byte_en = 3'b011;
      end
      if (k == 8) req_valid = 1'b0;
      @(negedge rcc_hclk);
      if (k == 3 || k == 4)        strb = 3'b111;
      else if (k == 10 || k == 11) strb = 3'b011;
      else                         strb = 3'b000;
      if (wren0) w0_cnt++;
      check($sformatf("bb_strb_c%0d", k), {29'd0, wren2, wren1, wren0}, {29'd0, strb});
      check($sformatf("bb_ready_c%0d", k), {31'd0, req_ready}, (k == 7 || k == 14) ? 32'd1 : 32'd0);
      check($sformatf("bb_done_c%0d", k), {31'd0, done}, (k == 6 || k == 13) ? 32'd1 : 32'd0);
      check($sformatf("bb_wdata_c%0d", k), {8'd0, bdcr_wdata}, (k <= 7) ? 32'h111111 : 32'h222222);
    end
    check("bb_w0_width_total", w0_cnt, 32'd4);

`ifdef RCC_BDCR_WREN_SHADOW_EN
    // Shadow update of only the enabled byte
    @(posedge rcc_hclk); #1;
    rcc_rst = 1'b1;
    @(posedge rcc_hclk); #1;
    rcc_rst = 1'b0;
    @(negedge rcc_hclk);
    check("sh_reset", {8'd0, shadow_bdcr}, 32'd0);
    issue(24'h112233, 3'b010, 1'b1);
    @(posedge rcc_hclk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge rcc_hclk);
    @(negedge rcc_hclk);
    check("sh_value", {8'd0, shadow_bdcr}, 32'h002200);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
